// File: rtl/baseline_channel_sched_pkg.sv
// Shared constants and helpers for the multi-lead adaptive-baseline scheduler.
package baseline_channel_sched_pkg;

  localparam int FRAC_BITS = 8;

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/baseline_channel_sched_if.sv
// Lead-side and downstream handshake bundle for baseline_channel_sched.
interface baseline_channel_sched_if #(
  parameter int NCH = 4,
  parameter int W   = 16
);
  logic [NCH-1:0]         in_valid;
  logic [NCH*W-1:0]       in_data;
  logic [NCH-1:0]         in_ready;
  logic [NCH-1:0]         chan_en;
  logic [NCH-1:0]         chan_clr;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(NCH)-1:0] out_ch;
  logic [W-1:0]           out_data;

  modport master (
    output in_valid, in_data, chan_en, chan_clr, out_ready,
    input  in_ready, out_valid, out_ch, out_data
  );
  modport slave (
    input  in_valid, in_data, chan_en, chan_clr, out_ready,
    output in_ready, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/baseline_channel_sched_rr_arbiter.sv
// NCH-wide round-robin arbiter; pointer moves past the winner only when advance_i is set.
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req_i,
  input  logic                   advance_i,
  output logic [NCH-1:0]         gnt_o,
  output logic [$clog2(NCH)-1:0] gnt_idx_o,
  output logic                   gnt_vld_o
);
  localparam int IDX_W = $clog2(NCH);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int j;
    j         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      j = (int'(ptr_q) + i) % NCH;
      if (!gnt_vld_o && req_i[j]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IDX_W'(j);
        gnt_o[j]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_o && advance_i)
      ptr_d = (gnt_idx_o == IDX_W'(NCH - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/baseline_channel_sched.sv
// One adaptive-baseline datapath shared round-robin across NCH ECG leads.
// Optional FAST_ACQUIRE_EN: per-lead fast-converging acquisition phase.
module baseline_channel_sched
  import baseline_channel_sched_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int W           = 16,
  parameter int ACC_W       = 32,
  parameter int ALPHA_SH    = 4,
  parameter int FAST_SH     = 1,
  parameter int ACQ_SAMPLES = 64
) (
  input logic                    clk,
  input logic                    rst,
  baseline_channel_sched_if.slave bus
);
  localparam int IDX_W = $clog2(NCH);

  if (NCH < 2 || NCH > 16 || FAST_SH < 0 || ACQ_SAMPLES < 1) begin : g_param_chk
    $error("baseline_channel_sched: parameter out of range");
  end

  logic [NCH-1:0]            hold_vld_q, hold_vld_d, rdy;
  logic [NCH-1:0][W-1:0]     hold_x_q, hold_x_d;
  logic [NCH-1:0][ACC_W-1:0] base_q, base_d;
  logic [NCH-1:0]            gnt;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      gnt_vld, stall, issue, s2_fire;

  logic                      s1_vld_q;
  logic [IDX_W-1:0]          s1_ch_q;
  logic [W-1:0]              s1_x_q;
  logic                      out_vld_q;
  logic [IDX_W-1:0]          out_ch_q;
  logic [W-1:0]              out_data_q;

  logic signed [ACC_W-1:0]   bl, xe, cent_full, bl_new;
  logic signed [W-1:0]       cent;
  int                        sh;

  assign stall   = out_vld_q & ~bus.out_ready;
  assign issue   = gnt_vld & ~stall;
  assign s2_fire = s1_vld_q & ~stall;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (hold_vld_q & bus.chan_en),
    .advance_i(~stall),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .gnt_vld_o(gnt_vld)
  );

  // A hold slot can refill in the same cycle its content is issued.
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_x_d   = hold_x_q;
    rdy        = '0;
    for (int k = 0; k < NCH; k++) begin
      rdy[k] = ~hold_vld_q[k] | (gnt[k] & issue);
      if (gnt[k] & issue) hold_vld_d[k] = 1'b0;
      if (bus.in_valid[k] & rdy[k]) begin
        hold_vld_d[k] = 1'b1;
        hold_x_d[k]   = bus.in_data[k*W +: W];
      end
    end
  end

`ifdef FAST_ACQUIRE_EN
  localparam int ACQ_W = $clog2(ACQ_SAMPLES + 1);
  logic [NCH-1:0][ACQ_W-1:0] acq_q, acq_d;

  always_comb begin
    acq_d = acq_q;
    if (s2_fire && acq_q[s1_ch_q] != ACQ_W'(ACQ_SAMPLES))
      acq_d[s1_ch_q] = acq_q[s1_ch_q] + 1'b1;
    for (int k = 0; k < NCH; k++)
      if (bus.chan_clr[k]) acq_d[k] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) acq_q <= '0;
    else     acq_q <= acq_d;
  end

  always_comb sh = (acq_q[s1_ch_q] < ACQ_W'(ACQ_SAMPLES)) ? FAST_SH : ALPHA_SH;
`else
  always_comb sh = ALPHA_SH;
`endif

  // S2 reads the live regfile entry, so a same-lead sample right behind sees the update.
  always_comb begin
    bl        = $signed(base_q[s1_ch_q]);
    xe        = ACC_W'($signed(s1_x_q));
    cent_full = xe - (bl >>> FRAC_BITS);
    cent      = W'(sat_signed(64'(cent_full), W));
    bl_new    = bl + (((xe <<< FRAC_BITS) - bl) >>> sh);
  end

  always_comb begin
    base_d = base_q;
    if (s2_fire) base_d[s1_ch_q] = bl_new;
    for (int k = 0; k < NCH; k++)
      if (bus.chan_clr[k]) base_d[k] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= '0;
      hold_x_q   <= '0;
      base_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_x_q     <= '0;
      out_vld_q  <= 1'b0;
      out_ch_q   <= '0;
      out_data_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_x_q   <= hold_x_d;
      base_q     <= base_d;
      if (!stall) begin
        s1_vld_q <= issue;
        if (issue) begin
          s1_ch_q <= gnt_idx;
          s1_x_q  <= hold_x_q[gnt_idx];
        end
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_ch_q   <= s1_ch_q;
          out_data_q <= cent;
        end
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_vld_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_baseline_channel_sched.sv
// Self-checking bench for baseline_channel_sched: vector table, directed corners, random vs. model.
module tb_baseline_channel_sched;
  localparam int NCH = 4, W = 16, ALPHA_SH = 4, FAST_SH = 1, ACQ_SAMPLES = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  baseline_channel_sched_if #(.NCH(NCH), .W(W)) bus ();

  baseline_channel_sched #(
    .NCH(NCH), .W(W), .ACC_W(32), .ALPHA_SH(ALPHA_SH),
    .FAST_SH(FAST_SH), .ACQ_SAMPLES(ACQ_SAMPLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0, n_pass = 0, n_out = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: per-lead FIFO of accepted samples and a per-lead baseline.
  longint m_base[NCH];
  int     m_cnt[NCH];
  int     q_x[NCH][$];
  bit     sb_en = 1'b0;

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NCH; k++) s += q_x[k].size();
    return s;
  endfunction

  logic       pv_stall = 1'b0;
  logic [1:0] p_ch;
  logic [15:0] p_data;

  always @(negedge clk) begin
    longint x, bl, expv;
    int ch, sh;
    if (rst || !sb_en) begin
      for (int k = 0; k < NCH; k++) begin
        q_x[k].delete();
        m_base[k] = 0;
        m_cnt[k]  = 0;
      end
    end
    if (rst) begin
      pv_stall = 1'b0;
    end else begin
      if (pv_stall) begin
        chk("stall_hold_valid", bus.out_valid, 1);
        chk("stall_hold_ch", bus.out_ch, p_ch);
        chk("stall_hold_data", bus.out_data, p_data);
      end
      if (sb_en) begin
        if (bus.out_valid && bus.out_ready) begin
          ch = int'(bus.out_ch);
          n_out++;
          if (q_x[ch].size() == 0) begin
            n_chk++;
            $display("FAIL sb_spurious: output on ch %0d data %0d, required no output (nothing pending)",
                     ch, $signed(bus.out_data));
          end else begin
            x  = q_x[ch].pop_front();
            bl = m_base[ch];
            sh = ALPHA_SH;
`ifdef FAST_ACQUIRE_EN
            if (m_cnt[ch] < ACQ_SAMPLES) sh = FAST_SH;
            if (m_cnt[ch] < ACQ_SAMPLES) m_cnt[ch]++;
`endif
            expv = sat16(x - (bl >>> 8));
            m_base[ch] = longint'(int'(bl + ((x * 256 - bl) >>> sh)));
            chk("sb_data", longint'($signed(bus.out_data)), expv);
          end
        end
        for (int k = 0; k < NCH; k++)
          if (bus.in_valid[k] && bus.in_ready[k])
            q_x[k].push_back(int'($signed(bus.in_data[k*W +: W])));
      end
      pv_stall = bus.out_valid && !bus.out_ready;
      p_ch     = bus.out_ch;
      p_data   = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = '0;
    bus.chan_clr  = '0;
    bus.chan_en   = '1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drives one sample on an idle pipe; lat counts edges from input handshake to out_valid.
  task automatic send_and_wait(input int lead, input int x,
                               output int got_ch, output int got_data, output int lat);
    int n = 0;
    tick();
    bus.in_data[lead*W +: W] = W'(x);
    bus.in_valid[lead] = 1'b1;
    @(negedge clk);
    while (!bus.in_ready[lead] && n < 20) begin
      @(negedge clk);
      n++;
    end
    tick();
    bus.in_valid[lead] = 1'b0;
    lat = -1; got_ch = -1; got_data = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat      = i - 1;
        got_ch   = int'(bus.out_ch);
        got_data = int'($signed(bus.out_data));
        break;
      end
    end
  endtask

  typedef struct { int lead; int x; int exp; } vec_t;
  vec_t tbl[9];

  initial begin : main
    int gch, gdat, glat, expch, first, gaps, seen2, found;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int gch, gdat, glat, expch, first, gaps, seen2, found;
    bus.in_valid = '0; bus.in_data = '0; bus.chan_en = '1;
    bus.chan_clr = '0; bus.out_ready = 1'b1;

    // Reset state
    sb_en = 1'b1;
    do_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_ch", bus.out_ch, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 4'hF);

`ifndef FAST_ACQUIRE_EN
    tbl[0] = '{0, 1000, 1000};
    tbl[1] = '{0, 1000, 938};
    tbl[2] = '{0, 1000, 879};
    tbl[3] = '{1, -2000, -2000};
    tbl[4] = '{1, -2000, -1875};
    tbl[5] = '{2, 32767, 32767};
    tbl[6] = '{2, -32768, -32768};
    tbl[7] = '{3, -32768, -32768};
    tbl[8] = '{3, 32767, 32767};
    for (int i = 0; i < 9; i++) begin
      send_and_wait(tbl[i].lead, tbl[i].x, gch, gdat, glat);
      chk("tbl_latency", glat, 2);
      chk("tbl_ch", gch, tbl[i].lead);
      chk("tbl_data", gdat, tbl[i].exp);
    end
`else
    for (int i = 0; i < 10; i++) begin
      send_and_wait(0, 1000, gch, gdat, glat);
      if (i == 0) chk("t6_first", gdat, 1000);
      if (i == 1) chk("t6_second", gdat, 500);
    end
    chk("t6_tenth_below_10", (gdat < 10) ? 1 : 0, 1);
`endif

    // T2: all leads streaming, full rate round-robin
    do_reset();
    bus.in_valid = '1;
    expch = 0; first = -1; gaps = 0;
    for (int c = 0; c < 24; c++) begin
      bus.in_data = {$urandom, $urandom};
      @(negedge clk);
      if (bus.out_valid) begin
        if (first < 0) first = c;
        chk("t2_rr_ch", bus.out_ch, expch);
        expch = (expch + 1) % NCH;
      end else if (first >= 0) gaps++;
      tick();
    end
    chk("t2_started", (first >= 0) ? 1 : 0, 1);
    chk("t2_no_gaps", gaps, 0);

    // T3: downstream stall mid-stream
    for (int c = 0; c < 5; c++) begin
      bus.in_data = {$urandom, $urandom};
      tick();
    end
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.in_data = {$urandom, $urandom};
      tick();
    end
    @(negedge clk);
    chk("t3_in_ready_blocked", bus.in_ready, 0);
    tick();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    bus.in_valid = '0;
    for (int c = 0; c < 12; c++) tick();
    chk("t3_drained", pending(), 0);

    // T4: clear of lead 1 while its sample sits in S2
    sb_en = 1'b0;
    do_reset();
    send_and_wait(1, 1000, gch, gdat, glat);
    chk("t4_first", gdat, 1000);
    tick();
    bus.in_data[W +: W] = 16'd1000;
    bus.in_valid[1] = 1'b1;
    tick();
    bus.in_valid[1] = 1'b0;
    tick();
    bus.chan_clr[1] = 1'b1;
    tick();
    bus.chan_clr[1] = 1'b0;
    chk("t4_clr_valid", bus.out_valid, 1);
    chk("t4_clr_old_base", $signed(bus.out_data), 938);
    send_and_wait(1, 500, gch, gdat, glat);
    chk("t4_after_clr_ch", gch, 1);
    chk("t4_after_clr_data", gdat, 500);

    // T5: disabled lead is skipped, then released
    sb_en = 1'b1;
    do_reset();
    bus.chan_en = 4'b1011;
    bus.in_data[2*W +: W] = 16'd700;
    bus.in_valid[2] = 1'b1;
    seen2 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ch == 2'd2) seen2++;
      tick();
    end
    chk("t5_never_granted", seen2, 0);
    chk("t5_in_ready2_low", bus.in_ready[2], 0);
    bus.in_valid[2] = 1'b0;
    bus.chan_en = '1;
    found = 0;
    for (int c = 0; c < NCH + 2 && found == 0; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ch == 2'd2) found = 1;
      tick();
    end
    chk("t5_released", found, 1);
    for (int c = 0; c < 6; c++) tick();
    chk("t5_drained", pending(), 0);

    // Random traffic against the model, with a reset in the middle
    do_reset();
    n_out = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 701) begin
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 4'hF);
      end
      bus.in_valid  = NCH'($urandom);
      bus.in_data   = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (c % 100 == 50) bus.chan_en = NCH'($urandom);
      if (c % 100 == 80) bus.chan_en = '1;
      rst = (c == 700);
      tick();
    end
    rst = 1'b0;
    bus.in_valid = '0; bus.chan_en = '1; bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    chk("rand_drained", pending(), 0);
    chk("rand_outputs_seen", (n_out > 300) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
